// File: rtl/rr_burst_bus_arbiter.sv
// Purpose : round-robin arbiter for NREQ bus masters with burst data-phase control and stall abort.
// Latency : grant/frame rise one cycle after a request is sampled in IDLE; one idle cycle between bursts.
// Backpress: dbusy_n=0 stalls the current beat; TIMEOUT consecutive stalled cycles abort with time_out.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req[NREQ]           level requests, one per master
//   req_len[NREQ*LEN_W] per-master burst length minus 1, field i at [i*LEN_W +: LEN_W]
//   dbusy_n             target ready (0 = busy, beat stalls)
//   grant[NREQ]         registered one-hot grant
//   frame               burst in progress
//   dbus_enb            beat transfers this cycle
//   data_last           current beat is the final beat
//   time_out            one-cycle pulse when a stalled burst is aborted
//   beat_cnt            index of the current beat
module rr_burst_bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16,
   parameter int TIMEOUT   = 8,
   parameter int LEN_W     = $clog2(MAX_BURST)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] req_len,
   input  logic                  dbusy_n,
   output logic [NREQ-1:0]       grant,
   output logic                  frame,
   output logic                  dbus_enb,
   output logic                  data_last,
   output logic                  time_out,
   output logic [LEN_W-1:0]      beat_cnt
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {IDLE, XFR} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [BW-1:0]     busy_q, busy_d;
   logic [IW-1:0]     last_q, last_d;
   logic              tout_q, tout_d;

   logic [IW-1:0]     win;
   logic [IW-1:0]     idx;
   logic              found;
   logic [LEN_W-1:0]  sel_len;

   // Rotating priority: scan from the master after the last winner, wrapping.
   always_comb begin
      win   = last_q;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last_q) + i) % NREQ);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_len = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) sel_len = req_len[i*LEN_W +: LEN_W];
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      len_d   = len_q;
      beat_d  = beat_q;
      busy_d  = busy_q;
      last_d  = last_q;
      tout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d      = XFR;
               grant_d      = '0;
               grant_d[win] = 1'b1;
               len_d        = sel_len;
               beat_d       = '0;
               busy_d       = '0;
               last_d       = win;
            end
         end
         XFR: begin
            if (!dbusy_n) begin
               // Stall counting is independent of the beat index, so a stall
               // on the final beat still waits the full TIMEOUT cycles.
               if (busy_q == BW'(TIMEOUT - 1)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  beat_d  = '0;
                  busy_d  = '0;
                  tout_d  = 1'b1;
               end else begin
                  busy_d = busy_q + BW'(1);
               end
            end else begin
               busy_d = '0;
               if (beat_q == len_q) begin
                  state_d = IDLE;
                  grant_d = '0;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + LEN_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         busy_q  <= '0;
         last_q  <= IW'(NREQ - 1);
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         last_q  <= last_d;
         tout_q  <= tout_d;
      end
   end

   assign grant     = grant_q;
   assign frame     = (state_q == XFR);
   assign dbus_enb  = frame & dbusy_n;
   assign data_last = frame & (beat_q == len_q);
   assign time_out  = tout_q;
   assign beat_cnt  = beat_q;

endmodule

// File: tb/tb_rr_burst_bus_arbiter.sv
// Purpose : directed self-checking bench for rr_burst_bus_arbiter (NREQ=4, MAX_BURST=16, TIMEOUT=8).
// Latency : inputs change and outputs are sampled 1 time unit after the falling clock edge.
// Backpress: dbusy_n is driven directly from the scenario tasks.
module tb_rr_burst_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic        dbusy_n;
   logic [3:0]  grant;
   logic        frame;
   logic        dbus_enb;
   logic        data_last;
   logic        time_out;
   logic [3:0]  beat_cnt;

   int total = 0;
   int bad   = 0;

   rr_burst_bus_arbiter #(
      .NREQ      (4),
      .MAX_BURST (16),
      .TIMEOUT   (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .req_len   (req_len),
      .dbusy_n   (dbusy_n),
      .grant     (grant),
      .frame     (frame),
      .dbus_enb  (dbus_enb),
      .data_last (data_last),
      .time_out  (time_out),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      req     = '0;
      req_len = '0;
      dbusy_n = 1'b1;
      tick;
      tick;
      reset_n = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      logic [11:0] e;
      reset_n = 1'b0;
      req     = '0;
      req_len = '0;
      dbusy_n = 1'b1;
      tick;
      e = 12'b0;
      total++;
      if ({grant, frame, dbus_enb, data_last, time_out, beat_cnt} !== e) begin
         bad++;
         $display("FAIL reset_state got=%b exp=%b", {grant, frame, dbus_enb, data_last, time_out, beat_cnt}, e);
      end
      // requests must not be granted while reset is held
      req = 4'b1111;
      tick;
      total++;
      if ({grant, frame, dbus_enb, data_last, time_out, beat_cnt} !== e) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=%b", {grant, frame, dbus_enb, data_last, time_out, beat_cnt}, e);
      end
      req = '0;
      reset_n = 1'b1;
      tick;
   endtask

   task automatic test_single_burst;
      logic [10:0] e;
      req     = 4'b0001;
      req_len = {4'd0, 4'd0, 4'd0, 4'd3};
      dbusy_n = 1'b1;
      tick;
      req = '0;
      for (int i = 0; i < 4; i++) begin
         e = {4'b0001, 1'b1, 1'b1, (i == 3), 4'(i)};
         total++;
         if ({grant, frame, dbus_enb, data_last, beat_cnt} !== e) begin
            bad++;
            $display("FAIL single_burst beat=%0d got=%b exp=%b", i, {grant, frame, dbus_enb, data_last, beat_cnt}, e);
         end
         tick;
      end
      e = 11'b0;
      total++;
      if ({grant, frame, dbus_enb, data_last, beat_cnt} !== e) begin
         bad++;
         $display("FAIL single_burst_end got=%b exp=%b", {grant, frame, dbus_enb, data_last, beat_cnt}, e);
      end
      tick;
   endtask

   task automatic test_round_robin;
      logic [3:0] seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};
      do_reset;
      req     = 4'b1111;
      req_len = '0;
      dbusy_n = 1'b1;
      tick;
      for (int k = 0; k < 9; k++) begin
         total++;
         if (grant !== seq[k]) begin
            bad++;
            $display("FAIL round_robin step=%0d grant=%b exp=%b", k, grant, seq[k]);
         end
         tick;
      end
      req = '0;
      tick;
   endtask

   task automatic test_timeout;
      logic [7:0] e;
      req     = 4'b0100;
      req_len = {4'd0, 4'd1, 4'd0, 4'd0};
      dbusy_n = 1'b0;
      tick;
      req = '0;
      for (int i = 0; i < 8; i++) begin
         e = {4'b0100, 1'b1, 1'b0, 1'b0, 1'b0};
         total++;
         if ({grant, frame, dbus_enb, data_last, time_out} !== e) begin
            bad++;
            $display("FAIL timeout_stall cyc=%0d got=%b exp=%b", i, {grant, frame, dbus_enb, data_last, time_out}, e);
         end
         tick;
      end
      e = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
      total++;
      if ({grant, frame, dbus_enb, data_last, time_out} !== e) begin
         bad++;
         $display("FAIL timeout_pulse got=%b exp=%b", {grant, frame, dbus_enb, data_last, time_out}, e);
      end
      req     = 4'b1111;
      req_len = '0;
      dbusy_n = 1'b1;
      tick;
      // the aborted master keeps its turn used: master 3 is next
      e = {4'b1000, 1'b1, 1'b1, 1'b1, 1'b0};
      total++;
      if ({grant, frame, dbus_enb, data_last, time_out} !== e) begin
         bad++;
         $display("FAIL timeout_next_grant got=%b exp=%b", {grant, frame, dbus_enb, data_last, time_out}, e);
      end
      req = '0;
      tick;
      tick;
   endtask

   task automatic test_stall_last;
      logic [4:0] e;
      req     = 4'b0001;
      req_len = '0;
      dbusy_n = 1'b0;
      tick;
      req = '0;
      for (int i = 0; i < 8; i++) begin
         e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
         total++;
         if ({frame, dbus_enb, data_last, time_out, grant[0]} !== {e[4:1], 1'b1}) begin
            bad++;
            $display("FAIL stall_last cyc=%0d got=%b exp=%b", i, {frame, dbus_enb, data_last, time_out, grant[0]}, {e[4:1], 1'b1});
         end
         tick;
      end
      e = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      total++;
      if ({frame, dbus_enb, data_last, time_out, grant[0]} !== e) begin
         bad++;
         $display("FAIL stall_last_pulse got=%b exp=%b", {frame, dbus_enb, data_last, time_out, grant[0]}, e);
      end
      dbusy_n = 1'b1;
      tick;
   endtask

   task automatic test_dbusy_pattern;
      logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] bc  [6] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
      logic [7:0] e;
      req     = 4'b0010;
      req_len = {4'd0, 4'd0, 4'd3, 4'd0};
      dbusy_n = 1'b1;
      tick;
      req = '0;
      for (int j = 0; j < 6; j++) begin
         dbusy_n = pat[j];
         #1;
         e = {pat[j], bc[j], 1'b0, 1'b1, (j == 5)};
         total++;
         if ({dbus_enb, beat_cnt, time_out, frame, data_last} !== e) begin
            bad++;
            $display("FAIL dbusy_pattern cyc=%0d got=%b exp=%b", j, {dbus_enb, beat_cnt, time_out, frame, data_last}, e);
         end
         tick;
      end
      total++;
      if ({frame, time_out, grant} !== 6'b0) begin
         bad++;
         $display("FAIL dbusy_pattern_end got=%b exp=%b", {frame, time_out, grant}, 6'b0);
      end
      tick;
   endtask

   task automatic test_reset_mid_burst;
      logic [10:0] e;
      req     = 4'b0100;
      req_len = {4'd0, 4'd4, 4'd0, 4'd0};
      dbusy_n = 1'b1;
      tick;
      req = '0;
      tick;
      tick;
      e = {4'b0100, 1'b1, 1'b1, 1'b0, 4'd2};
      total++;
      if ({grant, frame, dbus_enb, data_last, beat_cnt} !== e) begin
         bad++;
         $display("FAIL reset_mid_setup got=%b exp=%b", {grant, frame, dbus_enb, data_last, beat_cnt}, e);
      end
      reset_n = 1'b0;
      #1;
      e = 11'b0;
      total++;
      if ({grant, frame, dbus_enb, data_last, beat_cnt} !== e) begin
         bad++;
         $display("FAIL reset_mid_async got=%b exp=%b", {grant, frame, dbus_enb, data_last, beat_cnt}, e);
      end
      tick;
      reset_n = 1'b1;
      req     = 4'b0011;
      req_len = '0;
      tick;
      total++;
      if ({grant, frame} !== 5'b00011) begin
         bad++;
         $display("FAIL reset_mid_regrant got=%b exp=%b", {grant, frame}, 5'b00011);
      end
      req = '0;
      tick;
      tick;
   endtask

   task automatic test_req_drop;
      logic [9:0] e;
      req     = 4'b0010;
      req_len = {4'd0, 4'd0, 4'd2, 4'd0};
      dbusy_n = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         e = {4'b0010, 1'b1, (i == 2), 4'(i)};
         total++;
         if ({grant, frame, data_last, beat_cnt} !== e) begin
            bad++;
            $display("FAIL req_drop beat=%0d got=%b exp=%b", i, {grant, frame, data_last, beat_cnt}, e);
         end
         if (i == 0) begin
            // request and length both withdrawn mid-burst
            req     = '0;
            req_len = '0;
         end
         tick;
      end
      total++;
      if ({grant, frame, data_last} !== 6'b0) begin
         bad++;
         $display("FAIL req_drop_end got=%b exp=%b", {grant, frame, data_last}, 6'b0);
      end
      tick;
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '0;
      req_len = '0;
      dbusy_n = 1'b1;
      test_reset;
      test_single_burst;
      test_round_robin;
      test_timeout;
      test_stall_last;
      test_dbusy_pattern;
      test_reset_mid_burst;
      test_req_drop;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog sim time expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/rr_burst_bus_arbiter.md
Name: rr_burst_bus_arbiter

Overview:
- N-requester round-robin bus arbiter with burst data-phase control.
- Generalises the single-master grant/frame/data_last/time_out handshake to NREQ masters with per-request burst length and a parametrised busy timeout.
- Sits between the bus masters and the shared data bus.
- Drives one-hot grant, frame, dbus_enb and data_last; aborts a stalled burst with time_out.

Parameters:
- NREQ, 4, number of requesting masters (2..16).
- MAX_BURST, 16, maximum beats per burst (power of 2, ≥2).
- TIMEOUT, 8, consecutive busy cycles within a burst before abort (≥1).
- LEN_W, $clog2(MAX_BURST), width of each length field (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active low.
- req  in  NREQ  per-master request, level.
- req_len  in  NREQ*LEN_W  per-master burst length minus 1. Field i is at bits [i*LEN_W +: LEN_W].
- dbusy_n  in  1  target ready; 0 = busy, beat stalls.
- grant  out  NREQ  one-hot grant, registered.
- frame  out  1  burst in progress, registered.
- dbus_enb  out  1  beat transfers this cycle; equals frame & dbusy_n.
- data_last  out  1  current beat is the final beat of the burst.
- time_out  out  1  one-cycle pulse when a burst is aborted.
- beat_cnt  out  LEN_W  index of the current beat.

Behaviour:
- Reset, asserted asynchronously at any time including mid-burst:
  - grant=0, frame=0, beat_cnt=0, time_out=0; dbus_enb=0 and data_last=0 follow from frame=0.
  - Internal: state=IDLE, busy counter=0, last_winner=NREQ-1, so req[0] has first priority.
- FSM states: IDLE, XFR.
- IDLE:
  - If req≠0 at edge k, the winner is the first set bit scanning from (last_winner+1) mod NREQ upward with wrap.
  - Winner's req_len field is latched into len_q.
  - From cycle k+1: grant=onehot(winner), frame=1, beat_cnt=0, state=XFR, last_winner=winner.
  - If req=0, stay in IDLE.
- XFR:
  - A beat completes on each cycle with dbusy_n=1.
  - beat_cnt increments by 1 after each completed beat.
  - data_last = frame & (beat_cnt==len_q).
  - When a beat completes with data_last=1, the next cycle has grant=0, frame=0, state=IDLE.
  - That guarantees at least one idle cycle between bursts; no back-to-back grants.
- Busy counter:
  - Counts consecutive XFR cycles with dbusy_n=0; resets to 0 on any cycle with dbusy_n=1.
  - When the counter equals TIMEOUT-1 and dbusy_n=0: next cycle time_out=1 for exactly one cycle, grant=0, frame=0, state=IDLE.
  - So time_out rises TIMEOUT cycles after the first busy cycle of an unbroken stall.
  - last_winner keeps the aborted master, so the next arbitration starts after it.
- Request changes during a burst:
  - req deasserted during XFR is ignored; the burst runs to completion or timeout.
  - req_len changes during XFR are ignored; len_q is held.
- Length boundaries:
  - req_len=0 gives a single-beat burst: data_last=1 on the first XFR cycle.
  - req_len=MAX_BURST-1 gives MAX_BURST beats; beat_cnt never wraps within a burst.
- The stall counter must count a full TIMEOUT cycles even when a stall starts on the last beat.
- Invariants:
  - grant is one-hot or zero.
  - grant≠0 iff frame=1.
  - dbus_enb and data_last are never 1 while frame=0.
  - time_out and frame are never both 1.

Test Plan:
- Reset, then req=4'b0001, req_len[0]=3, dbusy_n=1:
  - grant=0001 and frame=1 for exactly 4 cycles, starting 1 cycle after req is sampled.
  - data_last=1 only on beat_cnt=3; then grant=0 for at least 1 cycle.
- req=4'b1111 held, all lengths 0, dbusy_n=1:
  - grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- req[2] burst with len=1, dbusy_n=0 from the first XFR cycle, TIMEOUT=8:
  - frame stays high 8 cycles, then time_out=1 for one cycle with frame=0 and grant=0.
  - Next arbitration with req=4'b1111 grants master 3.
- Burst len=3 with dbusy_n pattern 1,0,0,1,1,1:
  - dbus_enb pattern 1,0,0,1,1,1; beat_cnt 0,1,1,1,2,3; no time_out.
- reset_n pulsed low on beat 2 of a 5-beat burst:
  - grant, frame, data_last and dbus_enb drop immediately, before the next clock edge.
  - After release with req=4'b0011, master 0 is granted first.
- req[1] drops after its first beat (len=2):
  - Burst still completes 3 beats with data_last on beat 2; grant[1] then clears.
